// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl
//   Reset sequencer for the flop-based datapath banks. All domain resets assert
//   asynchronously with `reset`; release is synchronised and staggered so that
//   domain k+1 never leaves reset before domain k.
//
//   Build option: define RST_SEQ_ACK_EN to replace the fixed GAP_CYCLES spacing
//   with a per-domain acknowledgement (ack_i).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   sw_rst_i   software reset request, level-sampled, only honoured in DONE
//   ack_i      (RST_SEQ_ACK_EN only) per-domain "out of reset" acknowledgement
//   rst_o      per-domain active-high reset, bit 0 released first
//   busy_o     high while any rst_o bit is asserted
//   done_o     high once every domain has been released
//   fsm_state  debug view of the sequencer state (SYNC=0 HOLD=1 GAP=2 DONE=3)
//
// Acknowledge handshake (RST_SEQ_ACK_EN): after rst_o[k] falls the sequencer
// samples ack_i[k] on every following edge; the first edge it is seen high
// releases rst_o[k+1] (or raises done_o for the last domain). ack_i bits of
// domains still in reset are never looked at.

module reset_seq_ctrl #(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_rst_i,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_OUT-1:0] ack_i,
`endif
    output logic [NUM_OUT-1:0] rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_OUT) + 1;

    localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

`ifdef RST_SEQ_ACK_EN
    localparam bit            ACK_MODE = 1'b1;
    localparam logic [IW-1:0] IDX_END  = IW'(NUM_OUT);
`else
    localparam bit            ACK_MODE = 1'b0;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OUT - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_OUT-1:0]     rst_q;
    logic                   done_q;
    logic                   rdy;
    logic                   hold_end;

    // Release of the reset flops depends only on the synchronised rdy, never on
    // the raw reset input.
    assign rdy = sync_q[SYNC_STAGES-1];

    // The edge on which rdy is first seen already counts as the first hold
    // edge, which is why SYNC hands over to HOLD with cnt = 1 and a one-cycle
    // hold releases domain 0 directly from SYNC.
    assign hold_end = ((state_q == S_SYNC) && rdy && (HOLD_CYCLES == 1)) ||
                      ((state_q == S_HOLD) && (cnt_q == HOLD_LAST));

`ifdef RST_SEQ_ACK_EN
    logic ack_hit;
    // idx_q points at the next domain to release, so the domain whose
    // acknowledgement is awaited is idx_q-1.
    assign ack_hit = |(ack_i & (ONE << (idx_q - IW'(1))));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= S_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};

            case (state_q)
                S_SYNC: begin
                    if (rdy) begin
                        state_q <= S_HOLD;
                        cnt_q   <= CW'(1);
                    end
                end

                S_HOLD: begin
                    cnt_q <= cnt_q + CW'(1);
                end

                S_GAP: begin
`ifdef RST_SEQ_ACK_EN
                    if (ack_hit) begin
                        if (idx_q == IDX_END) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rst_q <= rst_q & ~(ONE << idx_q);
                            idx_q <= idx_q + IW'(1);
                        end
                    end
`else
                    if (cnt_q == GAP_LAST) begin
                        rst_q <= rst_q & ~(ONE << idx_q);
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end

                S_DONE: begin
                    // Software reset re-runs hold and release but not the
                    // synchroniser, which is already settled.
                    if (sw_rst_i) begin
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_HOLD;
                    end
                end

                default: begin
                    state_q <= S_SYNC;
                end
            endcase

            // Domain 0 release overrides the SYNC/HOLD bookkeeping above.
            if (hold_end) begin
                rst_q[0] <= 1'b0;
                idx_q    <= IW'(1);
                cnt_q    <= '0;
                if ((NUM_OUT == 1) && !ACK_MODE) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_GAP;
                end
            end
        end
    end

    assign rst_o     = rst_q;
    assign busy_o    = |rst_q;
    assign done_o    = done_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl
//   Directed bench for reset_seq_ctrl. Expected rst_o/done_o/busy_o values are
//   derived from hand-computed release edges and pushed into a queue tagged with
//   the clock edge they belong to; a monitor on the falling edge pops and
//   compares every entry whose edge has been reached. A second instance checks
//   the NUM_OUT=1 / HOLD_CYCLES=1 corner.
//   Edges are counted from 1 at the first rising edge with reset low.

module tb_reset_seq_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       sw_rst_i = 1'b0;
    logic       sw2      = 1'b0;
    logic [3:0] rst_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] fsm_state;
    logic [0:0] rst2;
    logic       busy2;
    logic       done2;
    logic [1:0] state2;
`ifdef RST_SEQ_ACK_EN
    logic [3:0] ack_i = 4'h0;
    logic [0:0] ack2  = 1'b1;
`endif

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;

    // {edge[15:0], rst[3:0], done, busy}
    logic [21:0] exp_q[$];
    // {edge[15:0], rst, done, busy}
    logic [18:0] exp2_q[$];

    reset_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .sw_rst_i  (sw_rst_i),
`ifdef RST_SEQ_ACK_EN
        .ack_i     (ack_i),
`endif
        .rst_o     (rst_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .fsm_state (fsm_state)
    );

    reset_seq_ctrl #(
        .NUM_OUT     (1),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (4)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .sw_rst_i  (sw2),
`ifdef RST_SEQ_ACK_EN
        .ack_i     (ack2),
`endif
        .rst_o     (rst2),
        .busy_o    (busy2),
        .done_o    (done2),
        .fsm_state (state2)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge=%0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
        end
    endtask

    function automatic logic [3:0] exp_rst(input int e, input int r0, input int r1,
                                           input int r2, input int r3);
        return {e < r3, e < r2, e < r1, e < r0};
    endfunction

    task automatic push(input int e, input logic [3:0] r, input logic d);
        logic [15:0] e16;
        e16 = e[15:0];
        exp_q.push_back({e16, r, d, |r});
    endtask

    task automatic push_seq(input int from, input int to, input int r0, input int r1,
                            input int r2, input int r3, input int done_at);
        for (int e = from; e <= to; e++)
            push(e, exp_rst(e, r0, r1, r2, r3), e >= done_at);
    endtask

    task automatic push2_seq(input int release_at, input int done_at);
        logic [15:0] e16;
        for (int e = 1; e <= 4; e++) begin
            e16 = e[15:0];
            exp2_q.push_back({e16, e < release_at, e >= done_at, e < release_at});
        end
    endtask

    // Return at the falling edge that follows rising edge n.
    task automatic at_neg(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (edge_n != n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != n) check("wait_edge_timeout", edge_n, n);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || exp2_q.size() > 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("drain_timeout", exp_q.size() + exp2_q.size(), 0);
    endtask

    task automatic check_reset_state();
        check("reset_rst_o", rst_o, 4'hF);
        check("reset_done_o", done_o, 1'b0);
        check("reset_busy_o", busy_o, 1'b1);
        check("reset_fsm_state", fsm_state, 2'd0);
        check("reset_rst2", rst2, 1'b1);
        check("reset_done2", done2, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [21:0] e;
        logic [18:0] e2;
        while (exp_q.size() > 0 && int'(exp_q[0][21:6]) <= edge_n) begin
            e = exp_q.pop_front();
            if (int'(e[21:6]) < edge_n) begin
                check("sched_missed", edge_n, {16'd0, e[21:6]});
            end else begin
                check("rst_o", rst_o, e[5:2]);
                check("done_o", done_o, e[1]);
                check("busy_o", busy_o, e[0]);
            end
        end
        while (exp2_q.size() > 0 && int'(exp2_q[0][18:3]) <= edge_n) begin
            e2 = exp2_q.pop_front();
            if (int'(e2[18:3]) < edge_n) begin
                check("sched2_missed", edge_n, {16'd0, e2[18:3]});
            end else begin
                check("corner_rst_o", rst2, e2[2]);
                check("corner_done_o", done2, e2[1]);
                check("corner_busy_o", busy2, e2[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();

`ifdef RST_SEQ_ACK_EN
        // Acked release: ack_i[0] at edge 11, ack_i[1] 20 edges after rst_o[1]
        // falls, early ack_i[3] pulse at edge 20 ignored, ack_i[3] at 35.
        push_seq(1, 40, 10, 11, 31, 33, 35);
        push2_seq(3, 4);
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            at_neg(n);
            ack_i[0] = (n + 1 >= 11);
            ack_i[1] = (n + 1 >= 31);
            ack_i[2] = (n + 1 >= 33);
            ack_i[3] = (n + 1 == 20) || (n + 1 >= 35);
        end
        drain();
        check("ack_final_state", fsm_state, 2'd3);
`else
        // Power-on with sw_rst_i held high over edges 5..12 (ignored), then a
        // software reset sampled at edge 23.
        push_seq(1, 22, 10, 14, 18, 22, 22);
        push_seq(23, 44, 31, 35, 39, 43, 43);
        // sw_rst_i held high from edge 45 through 66: a sequence from 45, then
        // a re-trigger at 66 after exactly one DONE cycle.
        push_seq(45, 65, 53, 57, 61, 65, 65);
        push_seq(66, 88, 74, 78, 82, 86, 86);
        push2_seq(3, 3);
        reset = 1'b0;

        at_neg(4);  sw_rst_i = 1'b1;
        at_neg(12); sw_rst_i = 1'b0;
        at_neg(22); sw_rst_i = 1'b1;
        at_neg(23); sw_rst_i = 1'b0;
        at_neg(44); sw_rst_i = 1'b1;
        at_neg(66); sw_rst_i = 1'b0;
        drain();
        check("done_state", fsm_state, 2'd3);

        // Full reset, then a sub-cycle reset glitch mid-GAP at edge 16.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        push_seq(1, 16, 10, 14, 18, 22, 22);
        push2_seq(3, 3);
        reset = 1'b0;
        at_neg(16);
        #2 reset = 1'b1;
        #1;
        check("glitch_rst_o", rst_o, 4'hF);
        check("glitch_done_o", done_o, 1'b0);
        check("glitch_busy_o", busy_o, 1'b1);
        check("glitch_rst2", rst2, 1'b1);
        check("glitch_done2", done2, 1'b0);
        #1 reset = 1'b0;
        push_seq(1, 24, 10, 14, 18, 22, 22);
        push2_seq(3, 3);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
